// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// One transaction in flight; data wins by default, with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_if;
  logic       fetch_wins;

  // Fetch takes the port when data is absent or has used up its run of grants.
  assign fetch_wins = if_req && (!d_req || starve_cnt == 4'(STARVE_MAX));

  // The mem_* registers double as the command latch, so they hold between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_if   <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            owner_if   <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= '1;
            mem_addr   <= if_addr;
            mem_en     <= 1'b1;
            if_gnt     <= 1'b1;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (d_req) begin
            owner_if  <= 1'b0;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            d_gnt     <= 1'b1;
            state     <= ISSUE;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt < 4'(STARVE_MAX))
              starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (mem_we) begin
            state <= IDLE;
          end else begin
            lat_cnt <= 3'(MEM_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            if (owner_if) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and per-port read scoreboards.
// A second instance runs with single-cycle memory latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
  logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
  logic [3:0]  b_d_be = '0;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  logic [31:0] mem_arr [0:255];
  bit          written [0:255];
  logic [31:0] rd_pipe [0:1];
  logic [31:0] b_pipe;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] preload(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h080: return 32'h80800001;
      32'h000: return 32'hCAFE0000;
      32'h004: return 32'hCAFE0004;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (written[a[9:2]]) return mem_arr[a[9:2]];
    return preload(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory with a fixed read pipeline matching each instance's latency.
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : 32'hxxxxxxxx;
    rd_pipe[1] <= rd_pipe[0];
    b_pipe     <= (b_mem_en && !b_mem_we) ? mem_read(b_mem_addr) : 32'hxxxxxxxx;
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[9:2]] <= merge(mem_read(mem_addr), mem_wdata, mem_be);
      written[mem_addr[9:2]] <= 1'b1;
    end
  end
  assign mem_rdata   = rd_pipe[1];
  assign b_mem_rdata = b_pipe;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_be    = be;
    d_addr  = da;
    d_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every read-data pulse must match the oldest outstanding expectation of its port.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt_overlap", 32'(if_gnt & d_gnt), 32'd0);
      checkOutput("rvalid_overlap", 32'(if_rvalid & d_rvalid), 32'd0);
      checkOutput("if_rvalid_spurious", 32'(if_rvalid && if_q.size() == 0), 32'd0);
      checkOutput("d_rvalid_spurious", 32'(d_rvalid && d_q.size() == 0), 32'd0);
      if (if_rvalid && if_q.size() != 0) checkOutput("if_rdata_sb", if_rdata, if_q.pop_front());
      if (d_rvalid && d_q.size() != 0) checkOutput("d_rdata_sb", d_rdata, d_q.pop_front());
    end
  end

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if_q.push_back(data);
    for (int c = 1; c <= 5; c++) begin
      tick();
      checkOutput($sformatf("fetch_c%0d", c), {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid},
                  {28'h0, c == 1, 1'b0, c == 4, 1'b0});
      if (c == 1) begin
        checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
        checkOutput("fetch_mem_addr", mem_addr, addr);
        checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
        checkOutput("fetch_mem_be", 32'(mem_be), 32'hF);
        if_req = 1'b0;
      end
      if (c == 4) checkOutput("fetch_rdata", if_rdata, data);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    string order;
    logic  exp_i;
    logic [3:0] be;

    repeat (2) tick();
    checkOutput("reset_outputs", 32'(|{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_en, mem_we, mem_be, mem_addr, mem_wdata}), 32'd0);
    checkOutput("reset_outputs_b", 32'(|{b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en}), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] fetch with MEM_LAT=2");
    run_fetch(32'h100, 32'hDEADBEEF);

    $display("[TB] stores then fetch readback");
    for (int i = 0; i < 2; i++) begin
      be = (i == 0) ? 4'h3 : 4'h0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, be, 32'h40, (i == 0) ? 32'h1234 : 32'hFFFFFFFF);
      tick();
      checkOutput("store_gnt", {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'b0100);
      checkOutput("store_mem_en", 32'(mem_en), 32'd1);
      checkOutput("store_mem_we", 32'(mem_we), 32'd1);
      checkOutput("store_mem_be", 32'(mem_be), 32'(be));
      checkOutput("store_mem_addr", mem_addr, 32'h40);
      checkOutput("store_mem_wdata", mem_wdata, (i == 0) ? 32'h1234 : 32'hFFFFFFFF);
      d_req = 1'b0;
      tick();
      checkOutput("store_done_mem_en", 32'(mem_en), 32'd0);
      checkOutput("store_hold_addr", mem_addr, 32'h40);
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if_q.push_back(32'h00401234);
      tick();
      checkOutput("store_idle_after", 32'(if_gnt), 32'd1);
      if_req = 1'b0;
      repeat (4) tick();
    end

    $display("[TB] starvation ordering");
    order = "DDDDIDDDDI";
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    for (int g = 0; g < 10; g++) begin
      for (int k = 0; k < 20; k++) begin
        tick();
        if (if_gnt || d_gnt) break;
      end
      exp_i = (order[g] == "I");
      checkOutput($sformatf("starve_order_%0d", g), {30'h0, if_gnt, d_gnt}, exp_i ? 32'd2 : 32'd1);
      if (exp_i) if_q.push_back(mem_read(32'h200));
      else d_q.push_back(mem_read(32'h300));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (8) tick();
    checkOutput("starve_if_q_drained", 32'(if_q.size()), 32'd0);
    checkOutput("starve_d_q_drained", 32'(d_q.size()), 32'd0);

    $display("[TB] load and fetch pending together");
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    d_q.push_back(32'h80800001);
    if_q.push_back(mem_read(32'h104));
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("contend_c%0d", c), {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid},
                  {28'h0, c == 5, c == 1, c == 8, c == 4});
      if (c == 1) begin
        checkOutput("contend_load_addr", mem_addr, 32'h80);
        d_req = 1'b0;
      end
      if (c == 5) begin
        checkOutput("contend_fetch_addr", mem_addr, 32'h104);
        if_req = 1'b0;
      end
    end

    $display("[TB] reset during fetch wait");
    applyStimulus(1'b1, 32'h180, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if_q.push_back(mem_read(32'h180));
    tick();
    checkOutput("rstwait_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rstwait_outputs_zero", 32'(|{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_en, mem_we, mem_be, mem_addr, mem_wdata}), 32'd0);
    if_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkOutput("rstwait_no_rvalid", 32'(if_rvalid), 32'd0);
    end
    run_fetch(32'h100, 32'hDEADBEEF);

    $display("[TB] back-to-back loads with MEM_LAT=1");
    b_d_req  = 1'b1;
    b_d_addr = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checkOutput($sformatf("lat1_c%0d", c), {30'h0, b_d_gnt, b_d_rvalid},
                  {30'h0, c == 1 || c == 4, c == 3 || c == 6});
      if (c == 1) begin
        checkOutput("lat1_addr0", b_mem_addr, 32'h0);
        b_d_addr = 32'h4;
      end
      if (c == 3) checkOutput("lat1_rdata0", b_d_rdata, 32'hCAFE0000);
      if (c == 4) begin
        checkOutput("lat1_addr4", b_mem_addr, 32'h4);
        b_d_req = 1'b0;
      end
      if (c == 6) checkOutput("lat1_rdata4", b_d_rdata, 32'hCAFE0004);
    end
    repeat (3) tick();
    checkOutput("final_if_q_empty", 32'(if_q.size()), 32'd0);
    checkOutput("final_d_q_empty", 32'(d_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
